// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the riscv-tests completion monitor and its benches.
package riscv_test_monitor_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_REPORT = 2'd2
   } mon_state_t;

   localparam int          TNUM_REG_DEF   = 3;
   localparam int          DONE_REG_DEF   = 26;
   localparam int          RESULT_REG_DEF = 27;
   localparam logic [31:0] PASS_VAL       = 32'h1;
   localparam logic [31:0] DONE_VAL       = 32'h1;

endpackage

// File: rtl/riscv_test_monitor_chan.sv
// Per-core write-back snoop: shadows the test-number, result and done registers.
module test_monitor_chan
   import riscv_test_monitor_pkg::*;
#(
   parameter int DONE_REG   = DONE_REG_DEF,
   parameter int RESULT_REG = RESULT_REG_DEF,
   parameter int TNUM_REG   = TNUM_REG_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   output logic [31:0] tnum,
   output logic [31:0] res,
   output logic        done
);

   logic wr_ok;
   assign wr_ok = en && we && (waddr != 5'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tnum <= '0;
         res  <= '0;
         done <= 1'b0;
      end else if (wr_ok) begin
         if (waddr == 5'(TNUM_REG))   tnum <= wdata;
         if (waddr == 5'(RESULT_REG)) res  <= wdata;
         // done is sticky; only the exact end-of-test value arms it
         if (waddr == 5'(DONE_REG) && wdata == DONE_VAL) done <= 1'b1;
      end
   end

endmodule

// File: rtl/riscv_test_monitor.sv
// Test-completion monitor: waits for every core's DONE, settles, then reports
// pass/fail or a global timeout. All results are sticky until reset.
//
// state     | meaning
// ST_RUN    | test executing; waiting for all cores done or timeout
// ST_SETTLE | all done; counting SETTLE_CYC cycles for late RESULT writes
// ST_REPORT | terminal; outputs, shadows and cycle_cnt frozen
module riscv_test_monitor
   import riscv_test_monitor_pkg::*;
#(
   parameter int NCH         = 1,
   parameter int DONE_REG    = DONE_REG_DEF,
   parameter int RESULT_REG  = RESULT_REG_DEF,
   parameter int TNUM_REG    = TNUM_REG_DEF,
   parameter int SETTLE_CYC  = 5,
   parameter int TIMEOUT_CYC = 5000,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      wb_we,
   input  logic [5*NCH-1:0]    wb_waddr,
   input  logic [32*NCH-1:0]   wb_wdata,
   output logic                test_done,
   output logic                test_pass,
   output logic                test_timeout,
   output logic [NCH-1:0]      fail_mask,
   output logic [31:0]         fail_tnum,
   output logic [CNT_W-1:0]    cycle_cnt
);

   localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0]      ST_LAST = 32'(SETTLE_CYC - 1);

   mon_state_t     state, state_nxt;
   logic [31:0]    settle_cnt;
   logic [NCH-1:0] done_v, fail_v;
   logic [31:0]    tnum_v [NCH];
   logic [31:0]    res_v  [NCH];
   logic [31:0]    tnum_sel;
   logic           shadow_en, all_done, timeout_hit, settle_last;

   assign shadow_en = (state != ST_REPORT);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      test_monitor_chan #(
         .DONE_REG   (DONE_REG),
         .RESULT_REG (RESULT_REG),
         .TNUM_REG   (TNUM_REG)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .en    (shadow_en),
         .we    (wb_we[i]),
         .waddr (wb_waddr[5*i +: 5]),
         .wdata (wb_wdata[32*i +: 32]),
         .tnum  (tnum_v[i]),
         .res   (res_v[i]),
         .done  (done_v[i])
      );
      assign fail_v[i] = (res_v[i] != PASS_VAL);
   end

   // Lowest failing core wins: scan high to low so the last hit is the lowest index
   always_comb begin
      tnum_sel = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (fail_v[i]) tnum_sel = tnum_v[i];
      end
   end

   assign all_done    = &done_v;
   assign timeout_hit = TO_EN && (cycle_cnt == TO_LAST);
   assign settle_last = (SETTLE_CYC == 0) || (settle_cnt == ST_LAST);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_RUN: begin
            if (all_done)         state_nxt = ST_SETTLE;
            else if (timeout_hit) state_nxt = ST_REPORT;
         end
         ST_SETTLE: if (settle_last) state_nxt = ST_REPORT;
         ST_REPORT: state_nxt = ST_REPORT;
         default:   state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_RUN;
         settle_cnt   <= '0;
         cycle_cnt    <= '0;
         test_done    <= 1'b0;
         test_pass    <= 1'b0;
         test_timeout <= 1'b0;
         fail_mask    <= '0;
         fail_tnum    <= '0;
      end else begin
         state <= state_nxt;
         if (state != ST_REPORT && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
         unique case (state)
            ST_RUN: begin
               settle_cnt <= '0;
               if (!all_done && timeout_hit) begin
                  test_timeout <= 1'b1;
                  test_pass    <= 1'b0;
                  test_done    <= 1'b0;
                  fail_mask    <= ~done_v;
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               if (settle_last) begin
                  fail_mask <= fail_v;
                  test_pass <= ~|fail_v;
                  fail_tnum <= tnum_sel;
                  test_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: single-core pass/fail/timeout cases and a two-core case.
module tb_riscv_test_monitor;
   import riscv_test_monitor_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [0:0]  we_a = '0;
   logic [4:0]  waddr_a = '0;
   logic [31:0] wdata_a = '0;
   logic        done_a, pass_a, to_a;
   logic [0:0]  mask_a;
   logic [31:0] tnum_a, cnt_a;

   logic [1:0]  we_b = '0;
   logic [9:0]  waddr_b = '0;
   logic [63:0] wdata_b = '0;
   logic        done_b, pass_b, to_b;
   logic [1:0]  mask_b;
   logic [31:0] tnum_b, cnt_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   riscv_test_monitor #(.NCH(1), .TIMEOUT_CYC(50)) dut_a (
      .clk(clk), .rst(rst), .wb_we(we_a), .wb_waddr(waddr_a), .wb_wdata(wdata_a),
      .test_done(done_a), .test_pass(pass_a), .test_timeout(to_a),
      .fail_mask(mask_a), .fail_tnum(tnum_a), .cycle_cnt(cnt_a)
   );

   riscv_test_monitor #(.NCH(2)) dut_b (
      .clk(clk), .rst(rst), .wb_we(we_b), .wb_waddr(waddr_b), .wb_wdata(wdata_b),
      .test_done(done_b), .test_pass(pass_b), .test_timeout(to_b),
      .fail_mask(mask_b), .fail_tnum(tnum_b), .cycle_cnt(cnt_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Assert reset mid-cycle, then release 1 time unit after a rising edge.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
      we_a = 1'b1; waddr_a = a; wdata_a = d;
      tick();
      we_a = 1'b0;
   endtask

   task automatic wr_b(input int c, input logic [4:0] a, input logic [31:0] d);
      we_b = '0;
      we_b[c] = 1'b1;
      waddr_b[5*c +: 5] = a;
      wdata_b[32*c +: 32] = d;
      tick();
      we_b = '0;
   endtask

   initial begin
      // ---- reset state
      #12;
      check("rst_done", done_a, 0);
      check("rst_cnt",  cnt_a,  0);
      check("rst_to",   to_a,   0);
      @(posedge clk);
      #1 rst = 1'b1;

      // ---- test 1: pass, result visible six edges after the DONE write
      wr_a(5'd3, 32'd7);
      wr_a(5'd27, 32'd1);
      wr_a(5'd26, 32'd1);
      tick(5);
      check("t1_done_early", done_a, 0);
      tick();
      check("t1_done", done_a, 1);
      check("t1_pass", pass_a, 1);
      check("t1_tnum", tnum_a, 0);
      check("t1_mask", mask_a, 0);
      check("t1_cnt",  cnt_a,  9);
      tick(3);
      check("t1_cnt_frozen", cnt_a, 9);

      // ---- test 2: fail with test number; reset clears a finished report at once
      rst = 1'b0;
      #1;
      check("t2_rst_done", done_a, 0);
      check("t2_rst_pass", pass_a, 0);
      check("t2_rst_cnt",  cnt_a,  0);
      @(posedge clk);
      #1 rst = 1'b1;
      wr_a(5'd3, 32'd12);
      wr_a(5'd27, 32'd0);
      wr_a(5'd26, 32'd1);
      tick(6);
      check("t2_done", done_a, 1);
      check("t2_pass", pass_a, 0);
      check("t2_mask", mask_a, 1);
      check("t2_tnum", tnum_a, 12);
      check("t2_to",   to_a,   0);

      // ---- test 3: RESULT written inside the settle window still counts
      do_reset();
      wr_a(5'd26, 32'd1);
      tick();
      wr_a(5'd27, 32'd1);
      tick(3);
      check("t3_done_early", done_a, 0);
      tick();
      check("t3_done", done_a, 1);
      check("t3_pass", pass_a, 1);

      // ---- test 4a: timeout at cycle_cnt == 49
      do_reset();
      tick(49);
      check("t4a_cnt49", cnt_a, 49);
      check("t4a_to_early", to_a, 0);
      tick();
      check("t4a_to",   to_a,   1);
      check("t4a_done", done_a, 0);
      check("t4a_pass", pass_a, 0);
      check("t4a_mask", mask_a, 1);
      check("t4a_cnt",  cnt_a,  50);
      tick(3);
      check("t4a_cnt_frozen", cnt_a, 50);

      // ---- test 4b: DONE registered on the timeout cycle wins
      do_reset();
      tick(48);
      wr_a(5'd26, 32'd1);
      check("t4b_cnt49", cnt_a, 49);
      tick();
      check("t4b_to", to_a, 0);
      tick(5);
      check("t4b_done", done_a, 1);
      check("t4b_to2",  to_a,   0);
      check("t4b_mask", mask_a, 1);
      check("t4b_cnt",  cnt_a,  55);

      // ---- test 5: two cores, core1 fails, core0 done last
      do_reset();
      wr_b(1, 5'd3, 32'd4);
      wr_b(1, 5'd27, 32'd2);
      wr_b(1, 5'd26, 32'd1);
      wr_b(0, 5'd26, 32'd2);
      wr_b(0, 5'd0, 32'd1);
      wr_b(0, 5'd27, 32'd1);
      tick(8);
      check("t5_wait", done_b, 0);
      wr_b(0, 5'd26, 32'd1);
      tick(5);
      check("t5_done_early", done_b, 0);
      tick();
      check("t5_done", done_b, 1);
      check("t5_pass", pass_b, 0);
      check("t5_mask", mask_b, 2'b10);
      check("t5_tnum", tnum_b, 4);
      check("t5_cnt",  cnt_b,  21);

      // ---- test 6: reset during SETTLE, then a clean rerun
      do_reset();
      wr_a(5'd3, 32'd7);
      wr_a(5'd27, 32'd1);
      wr_a(5'd26, 32'd1);
      tick(3);
      check("t6_cnt_pre", cnt_a, 6);
      rst = 1'b0;
      #1;
      check("t6_rst_cnt",  cnt_a,  0);
      check("t6_rst_done", done_a, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick(3);
      check("t6_no_stale", done_a, 0);
      wr_a(5'd3, 32'd7);
      wr_a(5'd27, 32'd1);
      wr_a(5'd26, 32'd1);
      tick(6);
      check("t6_done", done_a, 1);
      check("t6_pass", pass_a, 1);
      check("t6_tnum", tnum_a, 0);
      check("t6_cnt",  cnt_a,  12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
